mps_il_frame_tx: RTL and testbench

Transmit-side framer for the MPS active-interlock path: captures each X/Y position/angle calculation result and interlock flag set on `datavalid`, then serialises it as a 7-word, 32-bit checksummed frame on a valid/ready stream toward the MPS fibre/aggregator link. It sits directly downstream of the X/Y interlock calculation pair and upstream of the link serialiser. It also keeps a saturating interlock trip counter, a frame sequence number and an overrun count.

---
 rtl/mps_il_pkg.sv | 25 ++
 rtl/mps_il_snap.sv | 37 +++
 rtl/mps_il_frame_tx.sv | 113 +++++++++++
 tb/tb_mps_il_frame_tx.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mps_il_pkg.sv
// mps_il_pkg: shared sync byte, frame word indices, flag bit positions, framer state and snapshot type
package mps_il_pkg;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [2:0] W_HDR = 3'd0;
  localparam logic [2:0] W_XCAL = 3'd1;
  localparam logic [2:0] W_YCAL = 3'd2;
  localparam logic [2:0] W_XERR = 3'd3;
  localparam logic [2:0] W_YERR = 3'd4;
  localparam logic [2:0] W_TRIP = 3'd5;
  localparam logic [2:0] W_CHK = 3'd6;
  localparam int F_X_PRE = 0;
  localparam int F_Y_PRE = 1;
  localparam int F_X_IL = 2;
  localparam int F_Y_IL = 3;
  localparam int F_IL_VALID = 4;
  typedef enum logic {IDLE, SEND} state_t;
  typedef struct packed {
    logic [7:0] flags;
    logic [31:0] x_cal;
    logic [31:0] y_cal;
    logic [31:0] x_err;
    logic [31:0] y_err;
    logic [15:0] trip;
  } snap_t;
endpackage

// File: rtl/mps_il_snap.sv
// mps_il_snap: two-slot snapshot buffer (clk, RESET_N, cap/snap_in capture, done = last word accepted; act = frame being sent, start = a frame begins at this edge, overrun = capture dropped)
module mps_il_snap import mps_il_pkg::*; (
  input logic clk,
  input logic RESET_N,
  input logic cap,
  input snap_t snap_in,
  input logic done,
  output snap_t act,
  output logic start,
  output logic overrun
);
  snap_t pnd;
  logic act_v;
  logic pnd_v;
  always_ff @(posedge clk)
    if (!RESET_N) begin
      act <= '0;
      pnd <= '0;
      act_v <= 1'b0;
      pnd_v <= 1'b0;
    end else if (done) begin
      act <= pnd_v ? pnd : snap_in;
      act_v <= pnd_v | cap;
      pnd <= (pnd_v & cap) ? snap_in : pnd;
      pnd_v <= pnd_v & cap;
    end else if (cap) begin
      if (!act_v) begin
        act <= snap_in;
        act_v <= 1'b1;
      end else if (!pnd_v) begin
        pnd <= snap_in;
        pnd_v <= 1'b1;
      end
    end
  assign start = done ? (pnd_v | cap) : (cap & ~act_v);
  assign overrun = ~done & cap & act_v & pnd_v;
endmodule

// File: rtl/mps_il_frame_tx.sv
// mps_il_frame_tx: captures interlock results on datavalid and streams 7-word XOR-checked frames on tx_data/tx_valid/tx_last/tx_ready; also trip_cnt and overrun_cnt
module mps_il_frame_tx import mps_il_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input logic clk,
  input logic RESET_N,
  input logic tx_enable,
  input logic datavalid,
  input logic il_valid,
  input logic x_pre_il,
  input logic y_pre_il,
  input logic x_il,
  input logic y_il,
  input logic [31:0] x_cal_out,
  input logic [31:0] y_cal_out,
  input logic [31:0] x_err,
  input logic [31:0] y_err,
  output logic [31:0] tx_data,
  output logic tx_valid,
  output logic tx_last,
  input logic tx_ready,
  output logic [15:0] trip_cnt,
  output logic [7:0] overrun_cnt
);
  state_t state;
  state_t state_n;
  logic [2:0] idx;
  logic [2:0] idx_n;
  logic [7:0] seq;
  logic [7:0] ovr_q;
  logic [31:0] csum;
  logic il_d;
  logic hs;
  logic done;
  logic start;
  logic overrun;
  snap_t act;
  snap_t snap_in;
  always_comb begin
    snap_in = '0;
    snap_in.flags[F_X_PRE] = x_pre_il;
    snap_in.flags[F_Y_PRE] = y_pre_il;
    snap_in.flags[F_X_IL] = x_il;
    snap_in.flags[F_Y_IL] = y_il;
    snap_in.flags[F_IL_VALID] = il_valid;
    snap_in.x_cal = x_cal_out;
    snap_in.y_cal = y_cal_out;
    snap_in.x_err = x_err;
    snap_in.y_err = y_err;
    snap_in.trip = trip_cnt;
  end
  mps_il_snap u_snap (
    .clk(clk),
    .RESET_N(RESET_N),
    .cap(datavalid & tx_enable),
    .snap_in(snap_in),
    .done(done),
    .act(act),
    .start(start),
    .overrun(overrun)
  );
  assign hs = tx_valid & tx_ready;
  assign done = hs & (idx == W_CHK);
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == IDLE) begin
      state_n = start ? SEND : IDLE;
      idx_n = W_HDR;
    end else if (done) begin
      state_n = start ? SEND : IDLE;
      idx_n = W_HDR;
    end else if (hs) begin
      idx_n = idx + 3'd1;
    end
  end
  // overrun is latched at frame start so the header stays stable under backpressure;
  // no drop can coincide with a frame start, so this equals the value seen at word0
  always_ff @(posedge clk)
    if (!RESET_N) begin
      state <= IDLE;
      idx <= W_HDR;
      seq <= '0;
      ovr_q <= '0;
      csum <= '0;
      overrun_cnt <= '0;
      trip_cnt <= '0;
      il_d <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (done) seq <= seq + 8'd1;
      if (start) begin
        csum <= '0;
        ovr_q <= overrun_cnt;
      end else if (hs) begin
        csum <= csum ^ tx_data;
      end
      if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      if ((x_il | y_il) && !il_d && trip_cnt != 16'hFFFF) trip_cnt <= trip_cnt + 16'd1;
      il_d <= x_il | y_il;
    end
  assign tx_valid = state == SEND;
  assign tx_last = tx_valid & (idx == W_CHK);
  always_comb
    tx_data = !tx_valid ? 32'h0 :
              idx == W_HDR ? {SYNC_BYTE, seq, ovr_q, act.flags} :
              idx == W_XCAL ? act.x_cal :
              idx == W_YCAL ? act.y_cal :
              idx == W_XERR ? act.x_err :
              idx == W_YERR ? act.y_err :
              idx == W_TRIP ? {16'h0000, act.trip} : csum;
endmodule

// File: tb/tb_mps_il_frame_tx.sv
// tb_mps_il_frame_tx: randomized and directed bench for mps_il_frame_tx against a queue-level frame model
module tb_mps_il_frame_tx;
  logic clk = 0;
  logic rst_n = 0;
  logic tx_enable = 0;
  logic datavalid = 0;
  logic il_valid = 0;
  logic x_pre_il = 0;
  logic y_pre_il = 0;
  logic x_il = 0;
  logic y_il = 0;
  logic tx_ready = 0;
  logic [31:0] x_cal = 0;
  logic [31:0] y_cal = 0;
  logic [31:0] x_e = 0;
  logic [31:0] y_e = 0;
  logic [31:0] tx_data;
  logic tx_valid;
  logic tx_last;
  logic [15:0] trip_cnt;
  logic [7:0] overrun_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mps_il_frame_tx dut (
    .clk(clk),
    .RESET_N(rst_n),
    .tx_enable(tx_enable),
    .datavalid(datavalid),
    .il_valid(il_valid),
    .x_pre_il(x_pre_il),
    .y_pre_il(y_pre_il),
    .x_il(x_il),
    .y_il(y_il),
    .x_cal_out(x_cal),
    .y_cal_out(y_cal),
    .x_err(x_e),
    .y_err(y_e),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .trip_cnt(trip_cnt),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct {
    logic [7:0] fl;
    logic [31:0] xc, yc, xe, ye;
    logic [15:0] tr;
  } snap_s;
  snap_s q[$];
  logic [31:0] w[7];
  int pos = 0;
  int m_seq = 0;
  int m_ovr = 0;
  int m_trip = 0;
  bit m_il_d = 0;
  logic e_valid = 0;
  logic e_last = 0;
  logic [31:0] e_data = 0;
  logic [15:0] e_trip = 0;
  logic [7:0] e_ovr = 0;

  // frames waiting to go out are a queue of at most two snapshots; the head's words
  // are built from the live seq/overrun when it becomes the head
  task automatic model_step();
    snap_s s;
    bit newhead = 0;
    bit il = x_il | y_il;
    if (!rst_n) begin
      q.delete();
      pos = 0;
      m_seq = 0;
      m_ovr = 0;
      m_trip = 0;
      m_il_d = 0;
    end else begin
      s.fl = {3'b000, il_valid, y_il, x_il, y_pre_il, x_pre_il};
      s.xc = x_cal;
      s.yc = y_cal;
      s.xe = x_e;
      s.ye = y_e;
      s.tr = m_trip[15:0];
      if (q.size() > 0 && tx_ready) begin
        if (pos == 6) begin
          void'(q.pop_front());
          pos = 0;
          m_seq = (m_seq + 1) % 256;
          newhead = 1;
        end else pos++;
      end
      if (datavalid && tx_enable) begin
        if (q.size() < 2) begin
          q.push_back(s);
          if (q.size() == 1) newhead = 1;
        end else if (m_ovr < 255) m_ovr++;
      end
      if (il && !m_il_d && m_trip < 65535) m_trip++;
      m_il_d = il;
      if (newhead && q.size() > 0) begin
        w[0] = {8'hA5, m_seq[7:0], m_ovr[7:0], q[0].fl};
        w[1] = q[0].xc;
        w[2] = q[0].yc;
        w[3] = q[0].xe;
        w[4] = q[0].ye;
        w[5] = {16'h0000, q[0].tr};
        w[6] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
      end
    end
    e_valid = q.size() > 0;
    e_last = e_valid && pos == 6;
    e_data = e_valid ? w[pos] : 32'h0;
    e_trip = m_trip[15:0];
    e_ovr = m_ovr[7:0];
  endtask

  always @(posedge clk) model_step();

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    {tx_enable, datavalid, il_valid, x_pre_il, y_pre_il, x_il, y_il, tx_ready} = '0;
    x_cal = 0;
    y_cal = 0;
    x_e = 0;
    y_e = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tx_enable = 1;
    x_il = 1;
    datavalid = 1;
    x_cal = $urandom;
    @(negedge clk);
    datavalid = 0;
    repeat (3) @(negedge clk);
    do_reset();
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_cmp++;
    if (tx_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", tx_last); end
    n_cmp++;
    if (tx_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", tx_data); end
    n_cmp++;
    if (trip_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_trip: got %h want 0", trip_cnt); end
    n_cmp++;
    if (overrun_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_ovr: got %h want 0", overrun_cnt); end
  endtask

  task automatic test_basic();
    logic [31:0] want[7] = '{32'hA5000014, 32'h00001000, 32'hFFFFF000, 32'h00000001,
                             32'h00000002, 32'h00000001, 32'h5AFFE016};
    int k = 0;
    do_reset();
    tx_enable = 1;
    tx_ready = 1;
    x_il = 1;
    @(negedge clk);
    datavalid = 1;
    il_valid = 1;
    x_cal = 32'h0000_1000;
    y_cal = 32'hFFFF_F000;
    x_e = 1;
    y_e = 2;
    @(negedge clk);
    datavalid = 0;
    for (int c = 0; c < 12 && k < 7; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL basic_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (tx_data !== want[k] || tx_last !== (k == 6)) begin
          n_bad++;
          $display("FAIL basic_word%0d: got %h last=%b, want %h last=%b", k, tx_data, tx_last, want[k], k == 6);
        end
        k++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (k !== 7) begin n_bad++; $display("FAIL basic_count: got %0d words want 7", k); end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    int hs = 0;
    bit stalled = 0;
    logic [31:0] held = 0;
    logic held_last = 0;
    do_reset();
    tx_enable = 1;
    datavalid = 1;
    {il_valid, y_il, y_pre_il, x_pre_il} = 4'($urandom);
    x_cal = $urandom;
    y_cal = $urandom;
    x_e = $urandom;
    y_e = $urandom;
    @(negedge clk);
    datavalid = 0;
    for (int c = 0; c < 40 && hs < 7; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL bp_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      if (stalled) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== held || tx_last !== held_last) begin
          n_bad++;
          $display("FAIL bp_hold: got v%b d%h l%b, want v1 d%h l%b", tx_valid, tx_data, tx_last, held, held_last);
        end
      end
      tx_ready = (c % 2 == 0);
      if (tx_valid) cyc++;
      if (tx_valid && tx_ready) hs++;
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      held_last = tx_last;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc !== 13 || hs !== 7) begin n_bad++; $display("FAIL bp_cycles: got %0d cycles %0d words, want 13 and 7", cyc, hs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hdr[2];
    int frames = 0;
    int wi = 0;
    bit started = 0;
    bit gap = 0;
    do_reset();
    tx_enable = 1;
    tx_ready = 1;
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL b2b_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      if (started && frames < 2 && !tx_valid) gap = 1;
      if (tx_valid) begin
        started = 1;
        if (wi == 0 && frames < 2) hdr[frames] = tx_data;
        wi++;
        if (tx_last) begin frames++; wi = 0; end
      end
      datavalid = (c == 0 || c == 2 || c == 4);
      {il_valid, y_pre_il, x_pre_il} = 3'($urandom);
      x_cal = $urandom;
      y_cal = $urandom;
      x_e = $urandom;
      y_e = $urandom;
      @(negedge clk);
    end
    n_cmp++;
    if (frames !== 2) begin n_bad++; $display("FAIL b2b_frames: got %0d want 2", frames); end
    n_cmp++;
    if (gap !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got idle cycle between frames, want none"); end
    n_cmp++;
    if (hdr[0][23:16] !== 8'h00 || hdr[1][23:16] !== 8'h01) begin
      n_bad++;
      $display("FAIL b2b_seq: got %h,%h want 00,01", hdr[0][23:16], hdr[1][23:16]);
    end
    n_cmp++;
    if (hdr[1][15:8] !== 8'h01) begin n_bad++; $display("FAIL b2b_hdr_ovr: got %h want 01", hdr[1][15:8]); end
    n_cmp++;
    if (overrun_cnt !== 8'h01) begin n_bad++; $display("FAIL b2b_ovr: got %h want 01", overrun_cnt); end
  endtask

  task automatic test_trip();
    bit saw_valid = 0;
    do_reset();
    tx_ready = 1;
    for (int c = 0; c < 25; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL trip_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      if (tx_valid) saw_valid = 1;
      x_il = (c >= 2 && c <= 3) || (c >= 8 && c <= 9) || (c >= 14 && c <= 15);
      tx_enable = !(c >= 7 && c <= 10);
      datavalid = (c >= 8 && c <= 10);
      @(negedge clk);
    end
    n_cmp++;
    if (trip_cnt !== 16'd3) begin n_bad++; $display("FAIL trip_count: got %0d want 3", trip_cnt); end
    n_cmp++;
    if (saw_valid !== 1'b0 || overrun_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL trip_disabled_capture: got frame=%b ovr=%h want frame=0 ovr=00", saw_valid, overrun_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    tx_enable = 1;
    tx_ready = 1;
    x_il = 1;
    @(negedge clk);
    datavalid = 1;
    x_cal = $urandom;
    y_cal = $urandom;
    x_e = $urandom;
    y_e = $urandom;
    @(negedge clk);
    datavalid = 0;
    x_il = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_valid, tx_last, tx_data, trip_cnt} !== {1'b1, 1'b0, x_e, 16'd1}) begin
      n_bad++;
      $display("FAIL mid_word3: got v%b l%b d%h trip%h want v1 l0 d%h trip0001", tx_valid, tx_last, tx_data, trip_cnt, x_e);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0 || trip_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got v%b d%h trip%h want v0 d0 trip0", tx_valid, tx_data, trip_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_resume: got v%b want 0", tx_valid); end
    datavalid = 1;
    @(negedge clk);
    datavalid = 0;
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data[31:16] !== 16'hA500 || trip_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_restart: got v%b hdr%h trip%h want v1 hdrA500 trip0", tx_valid, tx_data[31:16], trip_cnt);
    end
    n_cmp++;
    if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
      n_bad++;
      $display("FAIL mid_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
               tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
    end
  endtask

  task automatic test_seq_wrap();
    int frames = 0;
    int wi = 0;
    logic [7:0] s255 = 8'h11;
    logic [7:0] s256 = 8'h11;
    do_reset();
    tx_enable = 1;
    tx_ready = 1;
    for (int c = 0; c < 257 * 7 + 20; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL wrap_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      if (tx_valid) begin
        if (wi == 0 && frames == 255) s255 = tx_data[23:16];
        if (wi == 0 && frames == 256) s256 = tx_data[23:16];
        wi++;
        if (tx_last) begin frames++; wi = 0; end
      end
      datavalid = (c % 7 == 0) && (c < 257 * 7);
      x_cal = $urandom;
      y_e = $urandom;
      {il_valid, x_pre_il} = 2'($urandom);
      @(negedge clk);
    end
    n_cmp++;
    if (frames !== 257) begin n_bad++; $display("FAIL wrap_frames: got %0d want 257", frames); end
    n_cmp++;
    if (s255 !== 8'hFF || s256 !== 8'h00) begin n_bad++; $display("FAIL wrap_seq: got %h,%h want ff,00", s255, s256); end
  endtask

  task automatic test_overrun_sat();
    do_reset();
    tx_enable = 1;
    tx_ready = 0;
    datavalid = 1;
    for (int c = 0; c < 302; c++) begin
      x_cal = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL sat_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
    end
    datavalid = 0;
    n_cmp++;
    if (overrun_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_ovr: got %h want ff", overrun_cnt); end
    tx_ready = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL sat_drain t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt} !== {e_valid, e_last, e_data, e_trip, e_ovr}) begin
        n_bad++;
        $display("FAIL rand_model t=%0t: got v%b l%b d%h trip%h ovr%h, want v%b l%b d%h trip%h ovr%h", $time,
                 tx_valid, tx_last, tx_data, trip_cnt, overrun_cnt, e_valid, e_last, e_data, e_trip, e_ovr);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tx_enable = ($urandom_range(0, 9) != 0);
      datavalid = ($urandom_range(0, 4) == 0);
      tx_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) {x_il, y_il} = 2'($urandom);
      {il_valid, x_pre_il, y_pre_il} = 3'($urandom);
      x_cal = $urandom;
      y_cal = $urandom;
      x_e = $urandom;
      y_e = $urandom;
      @(negedge clk);
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_trip();
    test_midframe_reset();
    test_seq_wrap();
    test_overrun_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
